// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin front end that shares one restoring-divider
// datapath between two requesters. It latches the winner's operands, pulses
// div_go, waits for div_done or a watchdog timeout, and returns the result
// with a one-cycle ack to whoever was granted.
module divider_arbiter #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] dividend_a,
    input  logic [WIDTH-1:0] dividend_b,
    input  logic [WIDTH-1:0] divisor_a,
    input  logic [WIDTH-1:0] divisor_b,
    output logic             ack_a,
    output logic             ack_b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             err,
    output logic             busy,
    output logic             div_go,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESPOND
    } state_t;

    // Last WAIT cycle index before the watchdog forces completion.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t           state;
    logic             last_grant;   // 0 = A served last, 1 = B served last
    logic [7:0]       wd_count;

    logic             pick_b;
    logic [WIDTH-1:0] sel_dividend;
    logic [WIDTH-1:0] sel_divisor;

    // Round-robin choice: on contention serve whoever was not served last.
    always_comb begin
        pick_b = 1'b0;
        if (req_a && req_b) begin
            pick_b = ~last_grant;
        end else begin
            pick_b = req_b;
        end
        sel_dividend = pick_b ? dividend_b : dividend_a;
        sel_divisor  = pick_b ? divisor_b  : divisor_a;
    end

    // Sequencer FSM with every output registered; ack and go are one-cycle pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            last_grant   <= 1'b1;
            wd_count     <= '0;
            ack_a        <= 1'b0;
            ack_b        <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
            err          <= 1'b0;
            busy         <= 1'b0;
            div_go       <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else begin
            ack_a  <= 1'b0;
            ack_b  <= 1'b0;
            div_go <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_a || req_b) begin
                        last_grant   <= pick_b;
                        div_dividend <= sel_dividend;
                        div_divisor  <= sel_divisor;
                        busy         <= 1'b1;
                        if (sel_divisor == '0) begin
                            state     <= ST_RESPOND;
                            quotient  <= '1;
                            remainder <= sel_dividend;
                            err       <= 1'b1;
                            ack_a     <= ~pick_b;
                            ack_b     <= pick_b;
                        end else begin
                            state  <= ST_ISSUE;
                            div_go <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    wd_count <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    wd_count <= wd_count + 8'd1;
                    if (div_done) begin
                        quotient  <= div_quotient;
                        remainder <= div_remainder;
                        err       <= 1'b0;
                        ack_a     <= ~last_grant;
                        ack_b     <= last_grant;
                        state     <= ST_RESPOND;
                    end else if (wd_count == TIMEOUT_LAST) begin
                        quotient  <= '0;
                        remainder <= '0;
                        err       <= 1'b1;
                        ack_a     <= ~last_grant;
                        ack_b     <= last_grant;
                        state     <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
